// File: rtl/usb_transmitter.sv
// Full-speed USB packet transmitter: SYNC, PID, optional payload + CRC16, EOP,
// with bit stuffing and NRZI encoding onto d_plus/d_minus.
module usb_transmitter #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [1:0] tx_packet,
    input  logic       data_valid,
    input  logic [7:0] data_byte,
    output logic       data_req,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_oe,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(MAX_BYTES + 1);

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J} state_t;

    state_t          state, nxt_state;
    logic [CW-1:0]   clk_cnt;
    logic [3:0]      bit_idx, nxt_idx;
    logic [2:0]      ones_cnt;
    logic            level;
    logic [7:0]      pid;
    logic            is_data;
    logic [6:0]      byte_rest;
    logic [BW-1:0]   byte_cnt;
    logic [15:0]     crc, crc_next;
    logic            busy_q, oe_q, done_q, req_q;
    logic            bit_end, stuff_due, can_load, byte_edge;
    logic            nxt_stuff, nxt_bit, load_byte, fb;

    function automatic logic [7:0] pid_of(input logic [1:0] kind);
        case (kind)
            2'd0:    pid_of = 8'hD2;
            2'd1:    pid_of = 8'h5A;
            2'd2:    pid_of = 8'hC3;
            default: pid_of = 8'h4B;
        endcase
    endfunction

    assign bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign stuff_due = (state inside {SYNC, PID, DATA, CRC}) && (ones_cnt == 3'd6);
    assign can_load  = data_valid && (byte_cnt < BW'(MAX_BYTES));

    // Decide what goes on the line for the next bit time; applied only at bit_end.
    always_comb begin
        nxt_state = state;
        nxt_idx   = bit_idx;
        nxt_stuff = 1'b0;
        nxt_bit   = 1'b1;
        load_byte = 1'b0;
        byte_edge = 1'b0;
        if (stuff_due) begin
            nxt_stuff = 1'b1;
            nxt_bit   = 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    if (bit_idx == 4'd7) begin
                        nxt_state = PID;
                        nxt_idx   = 4'd0;
                        nxt_bit   = pid[0];
                    end else begin
                        nxt_idx = bit_idx + 4'd1;
                        nxt_bit = (bit_idx == 4'd6);
                    end
                end
                PID: begin
                    if (bit_idx != 4'd7) begin
                        nxt_idx = bit_idx + 4'd1;
                        nxt_bit = pid[bit_idx[2:0] + 3'd1];
                    end else if (is_data) begin
                        byte_edge = 1'b1;
                    end else begin
                        nxt_state = EOP_SE0;
                        nxt_idx   = 4'd0;
                    end
                end
                DATA: begin
                    if (bit_idx != 4'd7) begin
                        nxt_idx = bit_idx + 4'd1;
                        nxt_bit = byte_rest[bit_idx[2:0]];
                    end else begin
                        byte_edge = 1'b1;
                    end
                end
                CRC: begin
                    if (bit_idx != 4'd15) begin
                        nxt_idx = bit_idx + 4'd1;
                        nxt_bit = ~crc[4'd14 - bit_idx];
                    end else begin
                        nxt_state = EOP_SE0;
                        nxt_idx   = 4'd0;
                    end
                end
                EOP_SE0: begin
                    if (bit_idx == 4'd0) begin
                        nxt_idx = 4'd1;
                    end else begin
                        nxt_state = EOP_J;
                        nxt_idx   = 4'd0;
                    end
                end
                EOP_J:   nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
            if (byte_edge) begin
                nxt_idx = 4'd0;
                if (can_load) begin
                    nxt_state = DATA;
                    nxt_bit   = data_byte[0];
                    load_byte = 1'b1;
                end else begin
                    nxt_state = CRC;
                    nxt_bit   = ~crc[15];
                end
            end
        end
    end

    assign fb       = nxt_bit ^ crc[15];
    assign crc_next = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= 4'd0;
            ones_cnt  <= 3'd0;
            level     <= 1'b1;
            pid       <= 8'h00;
            is_data   <= 1'b0;
            byte_rest <= 7'd0;
            byte_cnt  <= '0;
            crc       <= 16'hFFFF;
            busy_q    <= 1'b0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            req_q  <= 1'b0;
            if (state == IDLE) begin
                // The tx_done cycle still counts as busy for new requests.
                if (tx_start && !done_q) begin
                    state    <= SYNC;
                    clk_cnt  <= '0;
                    bit_idx  <= 4'd0;
                    ones_cnt <= 3'd0;
                    level    <= 1'b0;
                    pid      <= pid_of(tx_packet);
                    is_data  <= tx_packet[1];
                    byte_cnt <= '0;
                    busy_q   <= 1'b1;
                    oe_q     <= 1'b1;
                end
            end else if (!bit_end) begin
                clk_cnt <= clk_cnt + CW'(1);
            end else begin
                clk_cnt <= '0;
                state   <= nxt_state;
                bit_idx <= nxt_idx;
                case (nxt_state)
                    IDLE: begin
                        busy_q <= 1'b0;
                        oe_q   <= 1'b0;
                        done_q <= 1'b1;
                    end
                    EOP_SE0: ;
                    EOP_J:   level <= 1'b1;
                    default: begin
                        if (!nxt_bit) level <= ~level;
                        ones_cnt <= nxt_bit ? ones_cnt + 3'd1 : 3'd0;
                        if (nxt_state == DATA && !nxt_stuff) crc <= crc_next;
                        if (state == SYNC && nxt_state == PID) crc <= 16'hFFFF;
                    end
                endcase
                if (load_byte) begin
                    byte_rest <= data_byte[7:1];
                    byte_cnt  <= byte_cnt + BW'(1);
                    req_q     <= 1'b1;
                end
            end
        end
    end

    // Byte handshake: data_byte is captured at the edge that closes a cycle with
    // data_valid=1 at a byte boundary; data_req is high the cycle right after,
    // and the source advances to its next byte on that pulse.
    assign data_req = req_q;
    assign tx_busy  = busy_q;
    assign tx_oe    = oe_q;
    assign tx_done  = done_q;
    assign d_plus   = (state == EOP_SE0) ? 1'b0 : level;
    assign d_minus  = (state == EOP_SE0) ? 1'b0 : ~level;

endmodule

// File: tb/tb_usb_transmitter.sv
// Bench for usb_transmitter: builds each packet's expected line symbols from
// the field/stuff/NRZI rules and compares them bit time by bit time.
module tb_usb_transmitter;

  localparam int CPB  = 8;
  localparam int MAXB = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [1:0] tx_packet;
  logic       data_valid;
  logic [7:0] data_byte;
  logic       data_req, d_plus, d_minus, tx_oe, tx_busy, tx_done;

  int n_assert  = 0;
  int n_fail    = 0;
  int req_count = 0;

  logic [7:0] src_q[$];
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  usb_transmitter #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_packet(tx_packet),
    .data_valid(data_valid), .data_byte(data_byte), .data_req(data_req),
    .d_plus(d_plus), .d_minus(d_minus), .tx_oe(tx_oe),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  // byte source: presents src_q[0], pops it on each data_req pulse
  initial begin
    data_valid = 1'b0;
    data_byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (data_req === 1'b1) begin
        req_count++;
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      data_valid = (src_q.size() > 0);
      data_byte  = data_valid ? src_q[0] : 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pid_byte(input logic [1:0] p);
    logic [7:0] table_v [4];
    table_v = '{8'hD2, 8'h5A, 8'hC3, 8'h4B};
    return table_v[p];
  endfunction

  function automatic logic [15:0] crc16_bits(input bit bits[$], input int first);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = first; i < bits.size(); i++) begin
      if (bits[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // reference model: field list -> stuffed stream -> NRZI symbols -> EOP
  task automatic build_expected(input logic [1:0] pkt, input int nbytes);
    bit raw[$];
    bit pay[$];
    logic [7:0] pb;
    logic [15:0] c;
    int ones;
    logic [1:0] lvl;
    exp_q.delete();
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    pb = pid_byte(pkt);
    for (int i = 0; i < 8; i++) raw.push_back(pb[i]);
    if (pkt[1]) begin
      for (int b = 0; b < nbytes; b++)
        for (int i = 0; i < 8; i++) pay.push_back(src_q[b][i]);
      c = crc16_bits(pay, 0);
      foreach (pay[i]) raw.push_back(pay[i]);
      for (int i = 15; i >= 0; i--) raw.push_back(~c[i]);
    end
    ones = 0;
    lvl  = 2'b10;
    foreach (raw[i]) begin
      if (raw[i]) ones++; else ones = 0;
      if (!raw[i]) lvl = ~lvl;
      exp_q.push_back(lvl);
      if (ones == 6) begin
        ones = 0;
        lvl  = ~lvl;
        exp_q.push_back(lvl);
      end
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  // decode captured symbols (NRZI, unstuff) and check the CRC16 residual
  task automatic check_residual(input string tag, input int nbytes);
    bit dec[$];
    bit un[$];
    logic [1:0] prev;
    int ones;
    prev = 2'b10;
    foreach (obs_q[i]) begin
      if (obs_q[i] == 2'b00) break;
      dec.push_back(obs_q[i] == prev);
      prev = obs_q[i];
    end
    ones = 0;
    foreach (dec[i]) begin
      if (ones == 6) begin
        ones = 0;
      end else begin
        un.push_back(dec[i]);
        ones = dec[i] ? ones + 1 : 0;
      end
    end
    check({tag, " decoded length"}, un.size(), 32 + 8 * nbytes);
    check({tag, " crc residual"}, crc16_bits(un, 16), 16'h800D);
  endtask

  // driver task: called at a negedge with the source queue preloaded
  task automatic run_packet(input logic [1:0] pkt, input bit poke_busy,
                            input bit poke_done, input string tag);
    int nbytes, nbits, req_before, early_done;
    nbytes = 0;
    if (pkt[1]) nbytes = (src_q.size() > MAXB) ? MAXB : src_q.size();
    build_expected(pkt, nbytes);
    nbits      = exp_q.size();
    req_before = req_count;
    early_done = 0;
    obs_q.delete();
    tx_packet = pkt;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int c = 0; c < nbits * CPB; c++) begin
      if (c > 0) @(negedge clk);
      if (poke_busy && c == 70) begin
        tx_start  = 1'b1;
        tx_packet = ~pkt;
      end
      if (poke_busy && c == 71) tx_start = 1'b0;
      if (c % CPB == CPB / 2) begin
        obs_q.push_back({d_plus, d_minus});
        check($sformatf("%s line bit %0d", tag, c / CPB), {d_plus, d_minus}, exp_q[c / CPB]);
      end
      if (c == 0 || c == nbits * CPB - 1) begin
        check($sformatf("%s busy cycle %0d", tag, c), tx_busy, 1'b1);
        check($sformatf("%s oe cycle %0d", tag, c), tx_oe, 1'b1);
      end
      if (tx_done !== 1'b0) early_done++;
    end
    check({tag, " no early done"}, early_done, 0);
    @(negedge clk);
    check({tag, " done pulse"}, tx_done, 1'b1);
    check({tag, " busy low at done"}, tx_busy, 1'b0);
    check({tag, " oe low at done"}, tx_oe, 1'b0);
    check({tag, " line J at done"}, {d_plus, d_minus}, 2'b10);
    if (poke_done) begin
      tx_start  = 1'b1;
      tx_packet = 2'd2;
    end
    @(negedge clk);
    tx_start = 1'b0;
    check({tag, " done single"}, tx_done, 1'b0);
    check({tag, " stays idle"}, tx_busy, 1'b0);
    check({tag, " data_req count"}, req_count - req_before, nbytes);
    if (pkt[1]) check_residual(tag, nbytes);
  endtask

  initial begin
    int early_done;
    rst       = 1'b1;
    tx_start  = 1'b0;
    tx_packet = 2'd0;
    repeat (3) @(negedge clk);
    check("reset d_plus", d_plus, 1'b1);
    check("reset d_minus", d_minus, 1'b0);
    check("reset tx_oe", tx_oe, 1'b0);
    check("reset tx_busy", tx_busy, 1'b0);
    check("reset tx_done", tx_done, 1'b0);
    check("reset data_req", data_req, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ACK with pokes while busy and on the done cycle, then NAK right after
    run_packet(2'd0, 1'b1, 1'b1, "ack");
    run_packet(2'd1, 1'b0, 1'b0, "nak_after_done");

    // DATA0 zero-length
    run_packet(2'd2, 1'b0, 1'b0, "data0_empty");

    // DATA1 single 0xFF (stuff bit inside payload)
    src_q.push_back(8'hFF);
    run_packet(2'd3, 1'b0, 1'b0, "data1_ff");

    // payload cap: 72 bytes offered, 64 sent
    for (int i = 0; i < 72; i++) src_q.push_back(8'(i));
    run_packet(2'd2, 1'b0, 1'b0, "cap");
    check("cap leftover bytes", src_q.size(), 8);
    src_q.delete();
    repeat (2) @(negedge clk);

    // randomized packets
    for (int k = 0; k < 5; k++) begin
      logic [1:0] p;
      int len;
      p   = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) src_q.push_back(8'($urandom));
      run_packet(p, 1'b0, 1'b0, $sformatf("rand%0d", k));
      src_q.delete();
      repeat (2) @(negedge clk);
    end

    // reset in the middle of DATA
    for (int i = 0; i < 4; i++) src_q.push_back(8'($urandom));
    tx_packet = 2'd2;
    tx_start  = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst line", {d_plus, d_minus}, 2'b10);
    check("midrst tx_oe", tx_oe, 1'b0);
    check("midrst tx_busy", tx_busy, 1'b0);
    check("midrst tx_done", tx_done, 1'b0);
    check("midrst data_req", data_req, 1'b0);
    src_q.delete();
    early_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_done !== 1'b0) early_done++;
    end
    check("midrst no done", early_done, 0);
    run_packet(2'd0, 1'b0, 1'b0, "ack_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_transmitter.md
Name: usb_transmitter

Overview:
- Full-speed USB packet transmitter: the transmit-side counterpart of the bus receiver.
- Serialises handshake packets (ACK/NAK) and data packets (DATA0/DATA1) onto d_plus/d_minus.
- Per packet it sends SYNC, PID, payload bytes pulled from an upstream byte source, generated CRC16, and EOP.
- Applies bit stuffing and NRZI encoding; sits between the bridge packet controller/FIFO and the USB line driver.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit time (>=2)
MAX_BYTES, 64, maximum payload bytes per data packet

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tx_start  in  1  one-cycle request to send a packet; honoured only in IDLE
tx_packet  in  2  packet type sampled with tx_start: 0=ACK(0xD2), 1=NAK(0x5A), 2=DATA0(0xC3), 3=DATA1(0x4B)
data_valid  in  1  upstream has a payload byte on data_byte
data_byte  in  8  payload byte
data_req  out  1  one-cycle pulse: data_byte consumed this cycle
d_plus  out  1  line D+
d_minus  out  1  line D-
tx_oe  out  1  line driver enable
tx_busy  out  1  packet in progress
tx_done  out  1  one-cycle pulse on return to IDLE after EOP

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: d_plus=1, d_minus=0 (J/idle), tx_oe=0, tx_busy=0, tx_done=0, data_req=0; FSM returns to IDLE.
- Reset mid-packet: the packet is abandoned with no EOP, and the line is at J on the cycle after rst.
- FSM states: IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J.
- IDLE -> SYNC: on tx_start, which latches tx_packet. tx_busy and tx_oe rise the next cycle, and the first SYNC bit is driven that same cycle.
- tx_start is ignored while tx_busy=1.
- Bit timer: counts CLKS_PER_BIT cycles per bit. Line outputs change only at bit boundaries. Every state occupies whole bit times.
- Bit order: all fields go LSB first.
  - SYNC = 0x80, i.e. bits 0000000 then 1.
  - PID byte as listed for tx_packet.
- After PID:
  - ACK/NAK go directly to EOP_SE0.
  - DATA0/DATA1 go to DATA.
- DATA byte load: at each byte boundary (entering DATA, or after the 8th bit of a byte):
  - If data_valid=1 and fewer than MAX_BYTES have been sent, load data_byte and pulse data_req that cycle.
  - Otherwise go to CRC.
  - A zero-length payload is legal.
- CRC16:
  - Polynomial 0x8005, register initialised to 0xFFFF at PID start.
  - Updated with payload bits only, before stuffing: fb = bit ^ crc[15]; crc = {crc[14:0],0} ^ (fb ? 0x8005 : 0).
  - In CRC state the block sends ~crc[15] first down to ~crc[0], 16 bits.
- Bit stuffing:
  - Ones counter runs over the unencoded stream from the first SYNC bit through the last CRC bit.
  - After 6 consecutive 1s, one 0 bit time is inserted and the data shifter and CRC are held during it. The inserted bit resets the counter.
  - A stuff bit after the final CRC (or PID) bit is sent before EOP.
- NRZI: a 0 bit toggles the line between J (d_plus=1, d_minus=0) and K (0,1); a 1 bit holds. The line state before SYNC is J.
- EOP:
  - EOP_SE0: d_plus=d_minus=0 for 2 bit times.
  - EOP_J: J for 1 bit time.
  - Then IDLE: tx_oe=0, tx_busy=0, tx_done=1 for one cycle.
- data_req never pulses outside DATA state.
- data_valid/data_byte changes between byte boundaries have no effect.

Test Plan:
- ACK: tx_start, tx_packet=0, CLKS_PER_BIT=8 -> bits 00000001,01001011 NRZI-encoded, no stuff bits, 2 SE0 + 1 J. tx_busy high exactly 19*8=152 cycles. One tx_done pulse. data_req never asserted.
- DATA0 zero-length: data_valid=0 -> PID bits 11000011, then 16 zero CRC bits (~0xFFFF), then EOP. Total 35 bit times, no stuff bits.
- DATA1 with single byte 0xFF -> exactly one data_req pulse. One stuff bit inserted after the 6th payload 1 (line toggles there), 8 payload bits total. A decoder CRC16 over payload+CRC bits yields residual 0x800D.
- Payload cap: data_valid held 1 with counting bytes 0x00..0x47 -> exactly 64 data_req pulses (0x00..0x3F sent), then CRC. Decoded payload matches.
- tx_start pulsed during busy, and simultaneously with tx_done -> ignored while busy. Only the first packet is sent. A new tx_start one cycle after tx_done is honoured.
- rst asserted mid-DATA -> the next cycle shows d_plus=1, d_minus=0, tx_oe=0, tx_busy=0, no tx_done. A following ACK request transmits normally.
